// File: rtl/fft_controller.sv
// Sequencer for the variable-size radix-2 DIT FFT: bit-reversed load, per-stage
// butterfly issue and drain, ping-pong bank swap, then natural-order unload.
module fft_controller #(
   parameter int MAX_N      = 32,
   parameter int ADDR_WIDTH = $clog2(MAX_N),
   parameter int BF_LATENCY = 2
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH:0]   i_n,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   output logic                  o_load_we,
   output logic [ADDR_WIDTH-1:0] o_load_addr,
   output logic                  o_agu_reset_n,
   output logic                  o_agu_next_step,
   input  logic                  i_agu_done_fft,
   output logic                  o_rd_en,
   output logic                  o_wr_en,
   output logic                  o_bank_sel,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [ADDR_WIDTH-1:0] o_out_addr,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error,
   output logic [2:0]            o_state
);

   localparam int NW = ADDR_WIDTH + 1;
   localparam int SW = $clog2(ADDR_WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_COMPUTE = 3'd2,
      S_DRAIN   = 3'd3,
      S_SWAP    = 3'd4,
      S_UNLOAD  = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [NW-1:0]         r_n;
   logic [SW-1:0]         r_s;
   logic [SW-1:0]         r_stage;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic                  r_bank;
   logic                  r_error;
   logic [BF_LATENCY-1:0] r_sr;

   logic                  w_n_ok;
   logic [SW-1:0]         w_log2;
   logic [ADDR_WIDTH-1:0] w_rev;
   logic [SW-1:0]         w_shift;
   logic                  w_last_load;
   logic                  w_last_issue;
   logic                  w_last_drain;
   logic                  w_last_stage;
   logic                  w_err_set;
   logic                  w_rd_en;

   // Sizes must be a power of two between 4 and MAX_N; log2 is the set bit index.
   always_comb begin
      w_n_ok = (i_n >= NW'(4)) && (i_n <= NW'(MAX_N)) && ((i_n & (i_n - NW'(1))) == '0);
      w_log2 = '0;
      for (int k = 0; k < NW; k++) begin
         if (i_n[k]) w_log2 = SW'(k);
      end
   end

   // Full-width reversal, then shift down so only the low S bits are reversed.
   always_comb begin
      w_rev = '0;
      for (int k = 0; k < ADDR_WIDTH; k++) begin
         w_rev[k] = r_cnt[ADDR_WIDTH-1-k];
      end
      w_shift = SW'(ADDR_WIDTH) - r_s;
   end

   assign w_last_load  = ({1'b0, r_cnt} == (r_n - NW'(1)));
   assign w_last_issue = ({1'b0, r_cnt} == ((r_n >> 1) - NW'(1)));
   assign w_last_drain = (r_cnt == ADDR_WIDTH'(BF_LATENCY - 1));
   assign w_last_stage = (r_stage == (r_s - SW'(1)));

   always_comb begin
      w_next    = r_state;
      w_err_set = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               if (w_n_ok) w_next = S_LOAD;
               else        w_err_set = 1'b1;
            end
         end
         S_LOAD:    if (i_in_valid && w_last_load) w_next = S_COMPUTE;
         S_COMPUTE: if (w_last_issue) w_next = S_DRAIN;
         S_DRAIN:   if (w_last_drain) w_next = S_SWAP;
         S_SWAP: begin
            if (w_last_stage == i_agu_done_fft) begin
               w_next = w_last_stage ? S_UNLOAD : S_COMPUTE;
            end else begin
               w_next    = S_IDLE;
               w_err_set = 1'b1;
            end
         end
         S_UNLOAD:  if (i_out_ready && w_last_load) w_next = S_DONE;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   assign w_rd_en         = (r_state == S_COMPUTE);
   assign o_rd_en         = w_rd_en;
   assign o_agu_next_step = w_rd_en;
   assign o_agu_reset_n   = (r_state == S_COMPUTE) || (r_state == S_DRAIN) || (r_state == S_SWAP);
   assign o_in_ready      = (r_state == S_LOAD);
   assign o_load_we       = i_in_valid && o_in_ready;
   assign o_load_addr     = w_rev >> w_shift;
   assign o_out_valid     = (r_state == S_UNLOAD);
   assign o_out_addr      = r_cnt;
   assign o_busy          = (r_state != S_IDLE);
   assign o_done          = (r_state == S_DONE);
   assign o_error         = r_error;
   assign o_bank_sel      = r_bank;
   assign o_wr_en         = r_sr[BF_LATENCY-1];
   assign o_state         = r_state;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= S_IDLE;
         r_n     <= '0;
         r_s     <= '0;
         r_stage <= '0;
         r_cnt   <= '0;
         r_bank  <= 1'b0;
         r_error <= 1'b0;
         r_sr    <= '0;
      end else begin
         r_state <= w_next;
         if (w_next == S_IDLE) r_sr <= '0;
         else                  r_sr <= (r_sr << 1) | BF_LATENCY'(w_rd_en);
         if (w_err_set) r_error <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (i_start && w_n_ok) begin
                  r_n     <= i_n;
                  r_s     <= w_log2;
                  r_stage <= '0;
                  r_cnt   <= '0;
                  r_bank  <= 1'b0;
                  r_error <= 1'b0;
               end
            end
            S_LOAD: begin
               if (i_in_valid) r_cnt <= w_last_load ? '0 : r_cnt + ADDR_WIDTH'(1);
            end
            S_COMPUTE: r_cnt <= w_last_issue ? '0 : r_cnt + ADDR_WIDTH'(1);
            S_DRAIN:   r_cnt <= w_last_drain ? '0 : r_cnt + ADDR_WIDTH'(1);
            S_SWAP: begin
               r_bank  <= ~r_bank;
               r_stage <= r_stage + SW'(1);
               r_cnt   <= '0;
            end
            S_UNLOAD: begin
               if (i_out_ready) r_cnt <= w_last_load ? '0 : r_cnt + ADDR_WIDTH'(1);
            end
            default: r_cnt <= '0;
         endcase
      end
   end

endmodule
